// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//
// Owns the single-port instruction memory and walks it through three phases:
//   CLEAR : every word is written with zero, one word per cycle.
//   LOAD  : bytes from the boot loader are packed MSB-first into 32-bit words
//           and written in order (FLUSH writes a trailing partial word).
//   RUN   : the CPU is released and instruction fetches are served.
// Loader writes and fetch reads never overlap, because each phase owns the
// port exclusively.
//
// Ports:
//   clk, resetN              clock (rising edge), async active-low reset
//   ld_valid/ld_byte/ld_done loader byte stream and end-of-program pulse
//   ld_ready                 high while bytes are being accepted (LOAD)
//   ld_overflow              sticky: a byte arrived after memory was full
//   fetch_req/fetch_addr     fetch request with a byte address (PC)
//   fetch_valid/instr/err    fetch response, one cycle after the memory read
//   mem_we/addr/wdata/rdata  memory port (registered address; rdata follows
//                            one cycle after the address is presented)
//   cpu_run                  releases the CPU from reset (RUN)
//   words_loaded             number of program words written
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int MEM_SIZE = 256,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_done,
    output logic              ld_ready,
    output logic              ld_overflow,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_FLUSH,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [31:0]     BYTE_LIMIT = 32'(4 * MEM_SIZE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clrPtr_q, clrPtr_d;
    logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [1:0]          byteCnt_q, byteCnt_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_W:0]     wordsLoaded_q, wordsLoaded_d;
    logic                overflow_q, overflow_d;
    logic                memWe_q, memWe_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [31:0]         memWdata_q, memWdata_d;
    logic                reqPend_q, reqPend_d;
    logic                errPend_q, errPend_d;
    logic                fetchValid_q, fetchValid_d;
    logic                fetchErr_q, fetchErr_d;
    logic [31:0]         fetchInstr_q, fetchInstr_d;
    logic [1:0]          padBytes;

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_CLEAR;
            clrPtr_q      <= '0;
            wrPtr_q       <= '0;
            byteCnt_q     <= '0;
            asm_q         <= '0;
            wordsLoaded_q <= '0;
            overflow_q    <= 1'b0;
            memWe_q       <= 1'b0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            reqPend_q     <= 1'b0;
            errPend_q     <= 1'b0;
            fetchValid_q  <= 1'b0;
            fetchErr_q    <= 1'b0;
            fetchInstr_q  <= '0;
        end else begin
            state_q       <= state_d;
            clrPtr_q      <= clrPtr_d;
            wrPtr_q       <= wrPtr_d;
            byteCnt_q     <= byteCnt_d;
            asm_q         <= asm_d;
            wordsLoaded_q <= wordsLoaded_d;
            overflow_q    <= overflow_d;
            memWe_q       <= memWe_d;
            memAddr_q     <= memAddr_d;
            memWdata_q    <= memWdata_d;
            reqPend_q     <= reqPend_d;
            errPend_q     <= errPend_d;
            fetchValid_q  <= fetchValid_d;
            fetchErr_q    <= fetchErr_d;
            fetchInstr_q  <= fetchInstr_d;
        end
    end

    // Next-state and next-output logic for every phase.
    always_comb begin
        state_d       = state_q;
        clrPtr_d      = clrPtr_q;
        wrPtr_d       = wrPtr_q;
        byteCnt_d     = byteCnt_q;
        asm_d         = asm_q;
        wordsLoaded_d = wordsLoaded_q;
        overflow_d    = overflow_q;
        memWe_d       = 1'b0;
        memAddr_d     = memAddr_q;
        memWdata_d    = memWdata_q;
        reqPend_d     = 1'b0;
        errPend_d     = 1'b0;
        padBytes      = 2'd0;

        // Fetch response stage: the memory read launched last cycle is now on
        // mem_rdata; a rejected fetch returns a NOP and never touched memory.
        fetchValid_d = reqPend_q;
        fetchErr_d   = reqPend_q & errPend_q;
        fetchInstr_d = fetchInstr_q;
        if (reqPend_q) begin
            fetchInstr_d = errPend_q ? 32'h0 : mem_rdata;
        end

        case (state_q)
            S_CLEAR: begin
                memWe_d    = 1'b1;
                memAddr_d  = clrPtr_q;
                memWdata_d = 32'h0;
                clrPtr_d   = clrPtr_q + 1'b1;
                if (clrPtr_q == ADDR_W'(MEM_SIZE - 1)) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (ld_valid) begin
                    if (wordsLoaded_q == FULL_COUNT) begin
                        overflow_d = 1'b1;
                    end else begin
                        asm_d = {asm_q[23:0], ld_byte};
                        if (byteCnt_q == 2'd3) begin
                            memWe_d       = 1'b1;
                            memAddr_d     = wrPtr_q;
                            memWdata_d    = asm_d;
                            wrPtr_d       = wrPtr_q + 1'b1;
                            wordsLoaded_d = wordsLoaded_q + 1'b1;
                            byteCnt_d     = 2'd0;
                        end else begin
                            byteCnt_d = byteCnt_q + 2'd1;
                        end
                    end
                end
                // Done is evaluated after this cycle's byte has been taken.
                // A pending partial word is launched now so it is on the port
                // during FLUSH; left-justify by the number of missing bytes.
                if (ld_done) begin
                    if (byteCnt_d != 2'd0) begin
                        padBytes      = 2'd0 - byteCnt_d;
                        state_d       = S_FLUSH;
                        memWe_d       = 1'b1;
                        memAddr_d     = wrPtr_q;
                        memWdata_d    = asm_d << {padBytes, 3'b000};
                        wrPtr_d       = wrPtr_q + 1'b1;
                        wordsLoaded_d = wordsLoaded_q + 1'b1;
                        byteCnt_d     = 2'd0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_FLUSH: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (fetch_req) begin
                    reqPend_d = 1'b1;
                    if ((fetch_addr[1:0] != 2'b00) || (fetch_addr >= BYTE_LIMIT)) begin
                        errPend_d = 1'b1;
                    end else begin
                        memAddr_d = fetch_addr[ADDR_W+1:2];
                    end
                end
            end

            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    assign ld_ready     = (state_q == S_LOAD);
    assign cpu_run      = (state_q == S_RUN);
    assign ld_overflow  = overflow_q;
    assign words_loaded = wordsLoaded_q;
    assign mem_we       = memWe_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign fetch_valid  = fetchValid_q;
    assign fetch_err    = fetchErr_q;
    assign fetch_instr  = fetchInstr_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl
//
// Drives imem_load_ctrl with fixed and random programs, keeps a behavioural
// memory image of what the program should look like, and checks every memory
// write and every fetch response through two scoreboard queues that a
// free-running monitor drains.
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;

    localparam int MEM = 256;
    localparam int AW  = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } fe_t;

    logic          clk;
    logic          resetN;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_done;
    logic          ld_ready;
    logic          ld_overflow;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          cpu_run;
    logic [AW:0]   words_loaded;

    int nVec  = 0;
    int nMiss = 0;

    wr_t         writeQ[$];
    fe_t         fetchQ[$];
    wr_t         expW;
    fe_t         expF;
    logic [7:0]  prog[$];
    logic [31:0] refMem[MEM];
    logic [31:0] lastInstr;
    logic        clearPhase;
    logic [31:0] memArray[MEM];

    imem_load_ctrl #(.MEM_SIZE(MEM), .ADDR_W(AW)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_done      (ld_done),
        .ld_ready     (ld_ready),
        .ld_overflow  (ld_overflow),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_err    (fetch_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_run      (cpu_run),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array: the DUT's registered address acts as the RAM address
    // register, so read data appears in the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) memArray[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = memArray[mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportMissing(input string name, input logic [31:0] actual);
        nVec++;
        nMiss++;
        $display("[TB] FAIL %s: got output 0x%08h, expected no output at %0t", name, actual, $time);
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a write or a
    // fetch response, and checks that fetch_instr holds between responses.
    always @(negedge clk) begin
        if (resetN) begin
            if (mem_we && !clearPhase) begin
                if (writeQ.size() == 0) begin
                    reportMissing("spuriousWrite", mem_wdata);
                end else begin
                    expW = writeQ.pop_front();
                    checkOutput("writeAddr", {24'h0, mem_addr}, {24'h0, expW.addr});
                    checkOutput("writeData", mem_wdata, expW.data);
                end
            end
            if (fetch_valid) begin
                if (fetchQ.size() == 0) begin
                    reportMissing("spuriousFetch", fetch_instr);
                end else begin
                    expF = fetchQ.pop_front();
                    checkOutput("fetchErr", {31'h0, fetch_err}, {31'h0, expF.err});
                    checkOutput("fetchInstr", fetch_instr, expF.instr);
                end
                lastInstr = fetch_instr;
            end else begin
                checkOutput("instrHold", fetch_instr, lastInstr);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic d,
                                 input logic fr, input logic [31:0] fa);
        ld_valid   = v;
        ld_byte    = b;
        ld_done    = d;
        fetch_req  = fr;
        fetch_addr = fa;
        @(posedge clk);
        #1;
    endtask

    // Word w of the program: bytes 4w..4w+3 MSB-first, missing bytes are zero.
    function automatic logic [31:0] modelWord(input int w);
        logic [31:0] word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            word = word << 8;
            if (4 * w + k < prog.size()) word = word | {24'h0, prog[4 * w + k]};
        end
        return word;
    endfunction

    task automatic runClear();
        ld_valid = 1'b1;
        for (int i = 0; i < MEM; i++) begin
            ld_byte = 8'($urandom);
            ld_done = 1'($urandom_range(0, 1));
            if (i >= 250) begin
                ld_valid = 1'b0;
                ld_done  = 1'b0;
            end
            @(posedge clk);
            #1;
            checkOutput("clearWe", {31'h0, mem_we}, 32'h1);
            checkOutput("clearAddr", {24'h0, mem_addr}, i);
            checkOutput("clearData", mem_wdata, 32'h0);
            checkOutput("clearReady", {31'h0, ld_ready}, {31'h0, (i == MEM - 1)});
            checkOutput("clearRun", {31'h0, cpu_run}, 32'h0);
        end
        applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("clearEnd", {31'h0, mem_we}, 32'h0);
        checkOutput("clearWords", {23'h0, words_loaded}, 32'h0);
        checkOutput("loadReady", {31'h0, ld_ready}, 32'h1);
        checkOutput("loadRun", {31'h0, cpu_run}, 32'h0);
        clearPhase = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks that outputs drop without a clock edge,
    // then releases reset and follows the clear sweep.
    task automatic doReset();
        #3;
        resetN    = 1'b0;
        ld_valid  = 1'b0;
        ld_done   = 1'b0;
        fetch_req = 1'b0;
        #1;
        checkOutput("rstWe", {31'h0, mem_we}, 32'h0);
        checkOutput("rstAddr", {24'h0, mem_addr}, 32'h0);
        checkOutput("rstWdata", mem_wdata, 32'h0);
        checkOutput("rstReady", {31'h0, ld_ready}, 32'h0);
        checkOutput("rstOvf", {31'h0, ld_overflow}, 32'h0);
        checkOutput("rstRun", {31'h0, cpu_run}, 32'h0);
        checkOutput("rstFValid", {31'h0, fetch_valid}, 32'h0);
        checkOutput("rstFErr", {31'h0, fetch_err}, 32'h0);
        checkOutput("rstFInstr", fetch_instr, 32'h0);
        checkOutput("rstWords", {23'h0, words_loaded}, 32'h0);
        writeQ.delete();
        fetchQ.delete();
        lastInstr  = 32'h0;
        clearPhase = 1'b1;
        for (int i = 0; i < MEM; i++) refMem[i] = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        runClear();
    endtask

    task automatic loadProgram(input logic doneWithLast, input int gapPct);
        int len    = prog.size();
        int nWords = (len + 3) / 4;
        int k;
        if (nWords > MEM) nWords = MEM;
        for (int w = 0; w < nWords; w++) begin
            refMem[w] = modelWord(w);
            writeQ.push_back('{addr: AW'(w), data: refMem[w]});
        end
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 99) < gapPct) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 32'h0);
            applyStimulus(1'b1, prog[i], doneWithLast && (i == len - 1), 1'b0, 32'h0);
        end
        if (!doneWithLast || len == 0) applyStimulus(1'b0, 8'h0, 1'b1, 1'b0, 32'h0);
        k = 0;
        while (!cpu_run && k < 8) begin
            applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
            k++;
        end
        checkOutput("cpuRun", {31'h0, cpu_run}, 32'h1);
        applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("wordsLoaded", {23'h0, words_loaded}, nWords);
        checkOutput("overflow", {31'h0, ld_overflow}, {31'h0, (len > 4 * MEM)});
        checkOutput("writesDrained", writeQ.size(), 32'h0);
        checkOutput("readyInRun", {31'h0, ld_ready}, 32'h0);
    endtask

    function automatic fe_t modelFetch(input logic [31:0] a);
        fe_t r;
        r.err   = (a[1:0] != 2'b00) || (a >= 32'(4 * MEM));
        r.instr = r.err ? 32'h0 : refMem[a[AW+1:2]];
        return r;
    endfunction

    task automatic issueFetch(input logic fr, input logic [31:0] a);
        if (fr) fetchQ.push_back(modelFetch(a));
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), fr, a);
    endtask

    task automatic drainFetches();
        repeat (3) applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("fetchDrain", fetchQ.size(), 32'h0);
    endtask

    task automatic runFixedFetches();
        logic [31:0] fa[5] = '{32'h0, 32'h4, 32'h8, 32'h6, 32'h400};
        for (int k = 0; k < 5; k++) issueFetch(1'b1, fa[k]);
        drainFetches();
    endtask

    task automatic runFetches(input int n);
        logic [31:0] a;
        for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, 15)) << 2;
                4, 5:       a = 32'($urandom_range(0, MEM - 1)) << 2;
                6:          a = (32'($urandom_range(0, MEM - 1)) << 2) | 32'($urandom_range(1, 3));
                7:          a = 32'(4 * MEM - 4);
                8:          a = 32'(4 * MEM);
                default:    a = $urandom;
            endcase
            issueFetch($urandom_range(0, 99) < 80, a);
        end
        drainFetches();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN     = 1'b1;
        ld_valid   = 1'b0;
        ld_byte    = 8'h0;
        ld_done    = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        lastInstr  = 32'h0;
        clearPhase = 1'b1;

        $display("[TB] two-word program, done on its own cycle");
        doReset();
        prog = '{8'h20, 8'h11, 8'h00, 8'h01, 8'h20, 8'h12, 8'h00, 8'h02};
        loadProgram(1'b0, 0);
        runFixedFetches();
        runFetches(40);

        $display("[TB] done in the same cycle as the 4th byte");
        doReset();
        prog = '{8'h20, 8'h11, 8'h00, 8'hAA};
        loadProgram(1'b1, 0);
        runFixedFetches();

        $display("[TB] done after 3 bytes, partial word flushed");
        doReset();
        prog = '{8'h20, 8'h11, 8'h00};
        loadProgram(1'b0, 0);
        runFixedFetches();
        runFetches(20);

        $display("[TB] reset mid-load after 2 words");
        doReset();
        prog.delete();
        for (int i = 0; i < 10; i++) prog.push_back(8'($urandom));
        for (int w = 0; w < 2; w++) writeQ.push_back('{addr: AW'(w), data: modelWord(w)});
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, prog[i], 1'b0, 1'b0, 32'h0);
        repeat (3) applyStimulus(1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("preResetWrites", writeQ.size(), 32'h0);
        checkOutput("preResetWords", {23'h0, words_loaded}, 32'h2);
        doReset();
        prog.delete();
        loadProgram(1'b0, 0);
        runFixedFetches();

        $display("[TB] random programs");
        for (int r = 0; r < 4; r++) begin
            doReset();
            prog.delete();
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) prog.push_back(8'($urandom));
            loadProgram(1'($urandom_range(0, 1)), 30);
            runFetches(60);
        end

        $display("[TB] overflow: more bytes than the memory holds");
        doReset();
        prog.delete();
        for (int i = 0; i < 4 * MEM + 5; i++) prog.push_back(8'($urandom));
        loadProgram(1'b1, 0);
        runFetches(40);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
